snake_game_ctrl: RTL and testbench

//  Game-level controller downstream of the per-pixel collision detector.
//  - Accumulates per-frame collision codes and resolves them once per frame.
//  - Paces snake movement and tracks score and length.
//  - Sequences start, game-over and restart, driving restart/grow/respawn pulses to the snake, apple and collision blocks.

---
 rtl/snake_game_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game-level sequencer that sits after the per-pixel collision
// detector. It collects collision codes over a frame, resolves them at frame_end,
// paces snake movement, and keeps the BCD score and the snake length.
// Optional build macro: SPEEDUP_EN. When defined, every fifth apple shortens the
// move period by one frame, down to MIN_FRAMES_PER_MOVE.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset, waiting for the first start pulse
// RESTART | one cycle; game_reset pulses and all game state is reloaded
// PLAY    | collisions are collected and resolved at each frame_end
// OVER    | wall or body hit seen; waiting for start
module snake_game_ctrl #(
  parameter int unsigned FRAMES_PER_MOVE     = 8,
  parameter int unsigned MIN_FRAMES_PER_MOVE = 2,
  parameter int unsigned LEN_W               = 6,
  parameter int unsigned INIT_LEN            = 3,
  parameter int unsigned MAX_LEN             = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       collision,
  input  logic             frame_end,
  input  logic             start,
  output logic             game_reset,
  output logic             move_tick,
  output logic             grow,
  output logic             apple_respawn,
  output logic [7:0]       score,
  output logic [LEN_W-1:0] length,
  output logic             game_over,
  output logic             playing
);

  localparam int unsigned PER_W = $clog2(FRAMES_PER_MOVE + 1);
  localparam logic [PER_W-1:0] PERIOD_INIT = PER_W'(FRAMES_PER_MOVE);
  localparam logic [LEN_W-1:0] LEN_INIT    = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESTART = 2'd1,
    S_PLAY    = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [7:0]       score_q, score_nxt, score_inc;
  logic [LEN_W-1:0] length_q, length_nxt;
  logic [PER_W-1:0] frame_cnt_q, frame_cnt_nxt;
  logic [PER_W-1:0] period_q;
  logic             wall_seen_q, wall_seen_nxt;
  logic             apple_seen_q, apple_seen_nxt;
  logic             game_reset_q, game_reset_nxt;
  logic             move_tick_q, move_tick_nxt;
  logic             grow_q, grow_nxt;
  logic             respawn_q, respawn_nxt;
  logic             wall_now, apple_now, wall_hit, apple_hit;

`ifdef SPEEDUP_EN
  localparam logic [PER_W-1:0] PERIOD_MIN = PER_W'(MIN_FRAMES_PER_MOVE);
  logic [PER_W-1:0] period_nxt;
`else
  // The move period is a constant in this build; the floor parameter has no use.
  logic unused_min_period;
  assign unused_min_period = (MIN_FRAMES_PER_MOVE != 0);
  assign period_q          = PERIOD_INIT;
`endif

  // Code 11 is folded into the wall case so a corrupt code can only end a game.
  assign wall_now  = collision[1];
  assign apple_now = (collision == 2'b01);
  assign wall_hit  = wall_seen_q | wall_now;
  assign apple_hit = apple_seen_q | apple_now;

  // BCD +1 of the score, holding at 99.
  always_comb begin
    score_inc = score_q;
    if (score_q == 8'h99) begin
      score_inc = score_q;
    end else if (score_q[3:0] == 4'd9) begin
      score_inc = {score_q[7:4] + 4'd1, 4'd0};
    end else begin
      score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
    end
  end

  // Next-state and next-datapath logic; pulses default low every cycle.
  always_comb begin
    state_nxt      = state;
    score_nxt      = score_q;
    length_nxt     = length_q;
    frame_cnt_nxt  = frame_cnt_q;
    wall_seen_nxt  = wall_seen_q;
    apple_seen_nxt = apple_seen_q;
    game_reset_nxt = 1'b0;
    move_tick_nxt  = 1'b0;
    grow_nxt       = 1'b0;
    respawn_nxt    = 1'b0;
`ifdef SPEEDUP_EN
    period_nxt     = period_q;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt      = S_RESTART;
          game_reset_nxt = 1'b1;
        end
      end

      S_RESTART: begin
        score_nxt      = 8'h00;
        length_nxt     = LEN_INIT;
        frame_cnt_nxt  = '0;
        wall_seen_nxt  = 1'b0;
        apple_seen_nxt = 1'b0;
`ifdef SPEEDUP_EN
        period_nxt     = PERIOD_INIT;
`endif
        state_nxt      = S_PLAY;
      end

      S_PLAY: begin
        if (frame_end) begin
          wall_seen_nxt  = 1'b0;
          apple_seen_nxt = 1'b0;
          if (wall_hit) begin
            state_nxt = S_OVER;
          end else begin
            // Pacing compares the count before this frame is added in.
            if (frame_cnt_q == period_q - PER_W'(1)) begin
              move_tick_nxt = 1'b1;
              frame_cnt_nxt = '0;
            end else begin
              frame_cnt_nxt = frame_cnt_q + PER_W'(1);
            end
            if (apple_hit) begin
              grow_nxt    = 1'b1;
              respawn_nxt = 1'b1;
              score_nxt   = score_inc;
              length_nxt  = (length_q >= LEN_MAX) ? LEN_MAX : length_q + LEN_W'(1);
`ifdef SPEEDUP_EN
              // A held score at 99 is not a new multiple of five.
              if ((score_inc != score_q) &&
                  ((score_inc[3:0] == 4'd0) || (score_inc[3:0] == 4'd5)) &&
                  (period_q > PERIOD_MIN)) begin
                period_nxt = period_q - PER_W'(1);
                if (frame_cnt_nxt >= period_nxt) begin
                  frame_cnt_nxt = '0;
                end
              end
`endif
            end
          end
        end else begin
          wall_seen_nxt  = wall_seen_q | wall_now;
          apple_seen_nxt = apple_seen_q | apple_now;
        end
      end

      S_OVER: begin
        if (start) begin
          state_nxt      = S_RESTART;
          game_reset_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Score, length, pacing counter, sticky flags and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q      <= 8'h00;
      length_q     <= LEN_INIT;
      frame_cnt_q  <= '0;
      wall_seen_q  <= 1'b0;
      apple_seen_q <= 1'b0;
      game_reset_q <= 1'b0;
      move_tick_q  <= 1'b0;
      grow_q       <= 1'b0;
      respawn_q    <= 1'b0;
    end else begin
      score_q      <= score_nxt;
      length_q     <= length_nxt;
      frame_cnt_q  <= frame_cnt_nxt;
      wall_seen_q  <= wall_seen_nxt;
      apple_seen_q <= apple_seen_nxt;
      game_reset_q <= game_reset_nxt;
      move_tick_q  <= move_tick_nxt;
      grow_q       <= grow_nxt;
      respawn_q    <= respawn_nxt;
    end
  end

`ifdef SPEEDUP_EN
  // Move period register, shortened by the apple count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= PERIOD_INIT;
    end else begin
      period_q <= period_nxt;
    end
  end
`endif

  assign game_reset    = game_reset_q;
  assign move_tick     = move_tick_q;
  assign grow          = grow_q;
  assign apple_respawn = respawn_q;
  assign score         = score_q;
  assign length        = length_q;
  assign game_over     = (state == S_OVER);
  assign playing       = (state == S_PLAY);

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl. Directed scenarios followed by random stimulus,
// all checked against a frame-level behavioural model of the game rules.
module tb_snake_game_ctrl;

  localparam int FPM   = 8;
  localparam int MINP  = 2;
  localparam int LEN_W = 6;
  localparam int INIT  = 3;
  localparam int MAXL  = 63;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       collision;
  logic             frame_end;
  logic             start;
  logic             game_reset, move_tick, grow, apple_respawn, game_over, playing;
  logic [7:0]       score;
  logic [LEN_W-1:0] length;

  always #5 clk = ~clk;

  snake_game_ctrl #(
    .FRAMES_PER_MOVE    (FPM),
    .MIN_FRAMES_PER_MOVE(MINP),
    .LEN_W              (LEN_W),
    .INIT_LEN           (INIT),
    .MAX_LEN            (MAXL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .collision    (collision),
    .frame_end    (frame_end),
    .start        (start),
    .game_reset   (game_reset),
    .move_tick    (move_tick),
    .grow         (grow),
    .apple_respawn(apple_respawn),
    .score        (score),
    .length       (length),
    .game_over    (game_over),
    .playing      (playing)
  );

  int vectors    = 0;
  int miscompares = 0;
  int tick_seen  = 0;
  int grow_seen  = 0;

  // Model: game phase 0 idle, 1 restart, 2 play, 3 over; score kept in decimal.
  int m_phase, m_score, m_len, m_period, m_fcnt;
  bit m_wall, m_apple;
  bit e_reset, e_tick, e_grow, e_resp;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_len = INIT; m_period = FPM; m_fcnt = 0;
    m_wall = 0; m_apple = 0;
    e_reset = 0; e_tick = 0; e_grow = 0; e_resp = 0;
  endtask

  task automatic model_step(input bit s, input logic [1:0] c, input bit fe);
    e_reset = 0; e_tick = 0; e_grow = 0; e_resp = 0;
    case (m_phase)
      0, 3: if (s) begin m_phase = 1; e_reset = 1; end
      1: begin
        m_score = 0; m_len = INIT; m_period = FPM; m_fcnt = 0;
        m_wall = 0; m_apple = 0; m_phase = 2;
      end
      default: begin
        if (fe) begin
          if (m_wall || c[1]) begin
            m_phase = 3;
          end else begin
            if (m_fcnt == m_period - 1) begin e_tick = 1; m_fcnt = 0; end
            else m_fcnt = m_fcnt + 1;
            if (m_apple || c == 2'b01) begin
              e_grow = 1; e_resp = 1;
              m_len = (m_len < MAXL) ? m_len + 1 : MAXL;
              if (m_score < 99) begin
                m_score = m_score + 1;
`ifdef SPEEDUP_EN
                if (m_score % 5 == 0) begin
                  m_period = (m_period - 1 < MINP) ? MINP : m_period - 1;
                  if (m_fcnt >= m_period) m_fcnt = 0;
                end
`endif
              end
            end
          end
          m_wall = 0; m_apple = 0;
        end else begin
          if (c[1]) m_wall = 1;
          if (c == 2'b01) m_apple = 1;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("game_reset", 8'(game_reset), 8'(e_reset));
    chk("move_tick", 8'(move_tick), 8'(e_tick));
    chk("grow", 8'(grow), 8'(e_grow));
    chk("apple_respawn", 8'(apple_respawn), 8'(e_resp));
    chk("score", score, to_bcd(m_score));
    chk("length", 8'(length), 8'(m_len));
    chk("game_over", 8'(game_over), 8'(m_phase == 3));
    chk("playing", 8'(playing), 8'(m_phase == 2));
    if (move_tick === 1'b1) tick_seen++;
    if (grow === 1'b1) grow_seen++;
  endtask

  task automatic cycle(input bit s, input logic [1:0] c, input bit fe);
    @(negedge clk);
    start = s; collision = c; frame_end = fe;
    model_step(s, c, fe);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic frame(input logic [1:0] c_mid, input int n_mid, input logic [1:0] c_fe);
    for (int i = 0; i < n_mid; i++) cycle(1'b0, c_mid, 1'b0);
    cycle(1'b0, c_fe, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; start = 1'b0; frame_end = 1'b0; collision = 2'b00;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, exp_ticks;
    logic [1:0] c;
    bit fe, s;

    rst_n = 1'b0; start = 1'b0; frame_end = 1'b0; collision = 2'b00;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Start from idle: one game_reset cycle, then play with fresh state.
    cycle(1'b1, 2'b00, 1'b0);
    chk("start_reset_pulse", 8'(game_reset), 8'd1);
    cycle(1'b0, 2'b00, 1'b0);
    chk("play_after_restart", 8'(playing), 8'd1);
    chk("init_length", 8'(length), 8'd3);

    // Sixteen quiet frames: ticks on frames 8 and 16 only.
    tick_seen = 0; grow_seen = 0;
    for (int f = 0; f < 16; f++) frame(2'b00, 2, 2'b00);
    chk("ticks_16_frames", 8'(tick_seen), 8'd2);
    chk("no_grow_quiet", 8'(grow_seen), 8'd0);

    // Apple held for ten cycles gives exactly one grow.
    grow_seen = 0;
    frame(2'b01, 10, 2'b00);
    cycle(1'b0, 2'b00, 1'b0);
    chk("one_grow", 8'(grow_seen), 8'd1);
    chk("score_01", score, 8'h01);
    chk("length_4", 8'(length), 8'd4);

    // Wall and apple in one frame: wall wins.
    grow_seen = 0;
    cycle(1'b0, 2'b10, 1'b0);
    cycle(1'b0, 2'b01, 1'b0);
    cycle(1'b0, 2'b00, 1'b1);
    chk("over_on_wall", 8'(game_over), 8'd1);
    chk("score_kept", score, 8'h01);
    chk("no_grow_on_wall", 8'(grow_seen), 8'd0);
    frame(2'b00, 1, 2'b00);
    chk("fe_ignored_over", 8'(game_over), 8'd1);
    cycle(1'b1, 2'b00, 1'b0);
    chk("restart_pulse", 8'(game_reset), 8'd1);
    cycle(1'b1, 2'b00, 1'b0);
    chk("replay", 8'(playing), 8'd1);
    chk("score_cleared", score, 8'h00);

    // Speedup pacing after five apples from a fresh game.
    tick_seen = 0;
    for (int a = 0; a < 5; a++) frame(2'b00, 1, 2'b01);
    for (int f = 0; f < 16; f++) frame(2'b00, 2, 2'b00);
`ifdef SPEEDUP_EN
    exp_ticks = 3;
`else
    exp_ticks = 2;
`endif
    chk("ticks_after_5_apples", 8'(tick_seen), 8'(exp_ticks));

    // Score and length saturation over 100 apples.
    cycle(1'b0, 2'b11, 1'b1);
    cycle(1'b1, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 1'b0);
    for (int a = 0; a < 99; a++) frame(2'b00, 1, 2'b01);
    chk("score_99", score, 8'h99);
    frame(2'b00, 1, 2'b01);
    chk("grow_at_99", 8'(grow), 8'd1);
    chk("score_held_99", score, 8'h99);
    chk("length_sat", 8'(length), 8'd63);
    for (int f = 0; f < 6; f++) frame(2'b00, 1, 2'b00);

    // Asynchronous reset mid-game.
    do_reset();
    chk("reset_idle", 8'(playing), 8'd0);
    chk("reset_score", score, 8'h00);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      c = (r < 70) ? 2'b00 : (r < 88) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
      fe = ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle(s, c, fe);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
